// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Purpose  : Shared types and constants for the debounce filter slice.
//             Defines the four-state qualification FSM encoding, the
//             synchronizer depth, and the glitch counter width/limit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Qualification FSM. dout is high only in STABLE_HI and CAND_LO.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CAND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        CAND_LO   = 2'b11
    } state_e;

    localparam int                    SYNC_STAGES = 2;
    localparam int                    GLITCH_W    = 8;
    localparam logic [GLITCH_W-1:0]   GLITCH_MAX  = 8'hFF;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_filter_if.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_filter_if
//  Purpose  : Signal bundle between the debounce filter and its user.
//  Signals  : din        - raw input level (user -> filter)
//             clr_glitch - synchronous clear of glitch_cnt (user -> filter)
//             dout       - debounced level (filter -> user)
//             busy       - candidate transition being qualified
//             glitch_cnt - saturating count of rejected candidates
//  Modports : master - user side, slave - filter side
//  Revision : 1.0 - initial release
// ============================================================================
interface debounce_filter_if;
    import debounce_pkg::*;

    logic                din;
    logic                clr_glitch;
    logic                dout;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output din,
        output clr_glitch,
        input  dout,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  din,
        input  clr_glitch,
        output dout,
        output busy,
        output glitch_cnt
    );

endinterface : debounce_filter_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop level synchronizer bringing an asynchronous input
//             into the clk domain. Cleared by reset.
//  Ports    : clk    - clock, rising edge
//             resetn - synchronous active-low reset
//             d      - asynchronous input level
//             q      - synchronized level (SYNC_STAGES edges later)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff
    import debounce_pkg::*;
(
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic d,
    output      logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the new sample in at bit 0; bit SYNC_STAGES-1 is the output.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_filter
//  Purpose  : Level debouncer. A new input level is accepted only after it
//             has been sampled on STABLE_CYCLES consecutive clock edges;
//             shorter excursions are rejected and counted in a saturating
//             glitch counter.
//  Ports    : clk    - clock, rising edge
//             resetn - synchronous active-low reset
//             bus    - debounce_filter_if.slave (din, clr_glitch, dout,
//                      busy, glitch_cnt)
//  Params   : STABLE_CYCLES - edges of a new level needed (2..65535)
//             CNT_W         - stability counter width, 2**CNT_W > STABLE_CYCLES
//  Config   : DEBOUNCE_SYNC_EN - when defined, din passes a 2-flop
//             synchronizer first (adds 2 edges of latency); when undefined
//             din is used directly and must be synchronous to clk.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    debounce_filter_if.slave  bus
);

    // Counter value on the edge that completes qualification.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Sampled input
    // ------------------------------------------------------------------
    logic s;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.din),
        .q      (s)
    );
`else
    assign s = bus.din;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                dout_q,   dout_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_inc;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        glitch_inc = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    // The sample that opens the candidate already counts.
                    state_d = CAND_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end

            CAND_HI: begin
                if (s) begin
                    if (cnt_q == c_cnt_last) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        dout_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = STABLE_LO;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end
            end

            STABLE_HI: begin
                if (!s) begin
                    state_d = CAND_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end

            CAND_LO: begin
                if (!s) begin
                    if (cnt_q == c_cnt_last) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        dout_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = STABLE_HI;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end
            end

            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    // Clear wins over a simultaneous rejection; count sticks at the top.
    always_comb begin
        glitch_d = glitch_q;
        if (bus.clr_glitch) begin
            glitch_d = '0;
        end else if (glitch_inc && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            glitch_q <= glitch_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dout       = dout_q;
    assign bus.busy       = (state_q == CAND_HI) || (state_q == CAND_LO);
    assign bus.glitch_cnt = glitch_q;

endmodule : debounce_filter
`default_nettype wire

// File: tb/tb_debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_filter
//  Purpose  : Self-checking bench for debounce_filter (STABLE_CYCLES=4).
//             The stimulus process drives one vector per cycle and queues
//             the expected outputs after the following rising edge; a
//             monitor pops and compares one entry per cycle.
//  Config   : DEBOUNCE_SYNC_EN selects the synchronizer test sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_filter;

    typedef struct {
        logic       dout;
        logic       busy;
        logic [7:0] glitch;
    } exp_t;

    logic clk;
    logic resetn;

    debounce_filter_if dif ();

    debounce_filter #(
        .STABLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (dif.slave)
    );

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the
    // next rising edge.
    task automatic step(input logic d, input logic clr, input logic rn,
                        input logic ed, input logic eb, input int eg);
        exp_t e;
        @(negedge clk);
        dif.din        = d;
        dif.clr_glitch = clr;
        resetn         = rn;
        e.dout   = ed;
        e.busy   = eb;
        e.glitch = 8'(eg);
        exp_q.push_back(e);
    endtask

    // Monitor / scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (dif.dout !== e.dout) begin
                miscompares++;
                $display("FAIL dout vec=%0d got=%b exp=%b", vectors, dif.dout, e.dout);
            end
            if (dif.busy !== e.busy) begin
                miscompares++;
                $display("FAIL busy vec=%0d got=%b exp=%b", vectors, dif.busy, e.busy);
            end
            if (dif.glitch_cnt !== e.glitch) begin
                miscompares++;
                $display("FAIL glitch_cnt vec=%0d got=%0d exp=%0d", vectors, dif.glitch_cnt, e.glitch);
            end
        end
    end

    initial begin
        int g;
        dif.din        = 1'b0;
        dif.clr_glitch = 1'b0;
        resetn         = 1'b0;

`ifdef DEBOUNCE_SYNC_EN
        // Reset, then din rises and is held: busy from edge 3, dout at 6.
        repeat (2) step(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            step(1, 0, 1, i >= 6, (i >= 3) && (i <= 5), 0);
        // Return to a clean low state.
        repeat (2) step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        // din rises; reset hits on edge 3 before anything is accepted.
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // After release the synchronizer refills from zero.
        for (int i = 1; i <= 7; i++)
            step(1, 0, 1, i >= 6, (i >= 3) && (i <= 5), 0);
`else
        // Reset held 3 cycles with din high.
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Clean rising transition held 10 cycles.
        for (int i = 1; i <= 10; i++)
            step(1, 0, 1, i >= 4, i < 4, 0);

        // From high: low 2, high 1 (rejected), low 4 (accepted).
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0, 1);
        for (int i = 1; i <= 4; i++)
            step(0, 0, 1, i < 4, i < 4, 1);

        // 300 three-edge pulses, each rejected; count saturates at 255.
        g = 1;
        for (int k = 0; k < 300; k++) begin
            repeat (3) step(1, 0, 1, 0, 1, g);
            if (g < 255) g++;
            step(0, 0, 1, 0, 0, g);
        end

        // Clear coinciding with a rejection wins.
        step(1, 0, 1, 0, 1, 255);
        step(0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1);

        // Reset mid-qualification: no increment, counter cleared by reset,
        // qualification restarts from scratch afterwards.
        step(1, 0, 1, 0, 1, 1);
        step(1, 0, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(1, 0, 1, i >= 4, i < 4, 0);
        // Reset with dout high forces it low.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
`endif

        // Let the monitor consume the last vector.
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_debounce_filter
`default_nettype wire

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive sampling edges of a new level required to accept it; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the internal stability counter; SHALL satisfy 2**CNT_W > STABLE_CYCLES.
REQ-003 clk  input  1  block clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 din  input  1  raw, possibly bouncing or asynchronous level; the downstream edge detector consumes dout.
REQ-006 clr_glitch  input  1  synchronous clear of glitch_cnt.
REQ-007 dout  output  1  debounced level, registered.
REQ-008 busy  output  1  high while a candidate transition is being qualified.
REQ-009 glitch_cnt  output  8  saturating count of rejected candidate transitions.

Function
REQ-010 Sampled input s: the synchronizer output when sync is compiled in (REQ-024), else din directly.
REQ-011 FSM states: STABLE_LO, CAND_HI, STABLE_HI, CAND_LO; dout=1 only in STABLE_HI and CAND_LO.
REQ-012 STABLE_LO with s=1 -> CAND_HI, cnt=1; with s=0 -> stay, cnt=0.
REQ-013 CAND_HI with s=1 and cnt=STABLE_CYCLES-1 -> STABLE_HI, dout=1 on the same edge; with s=1 otherwise -> cnt+1.
REQ-014 CAND_HI with s=0 -> STABLE_LO, cnt=0, glitch_cnt+1.
REQ-015 STABLE_HI, CAND_LO mirror REQ-012..014 with levels inverted; CAND_LO -> STABLE_LO clears dout on the qualifying edge.
REQ-016 Latency: dout changes on the STABLE_CYCLES-th consecutive edge sampling the new level on s; sync adds exactly 2 edges from din.
REQ-017 A pulse on s shorter than STABLE_CYCLES edges SHALL never change dout.
REQ-018 busy = (state==CAND_HI || state==CAND_LO), decoded from the state register only.
REQ-019 glitch_cnt saturates at 255; no wrap.
REQ-020 clr_glitch=1 forces glitch_cnt to 0 on that edge, taking priority over a simultaneous increment.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1; no overflow path exists.

Reset
REQ-022 resetn=0 at a clock edge: state=STABLE_LO, cnt=0, dout=0, glitch_cnt=0, synchronizer flops=0.
REQ-023 Reset asserted mid-qualification aborts it without a glitch_cnt increment; after release qualification restarts from STABLE_LO.

Configuration
REQ-024 Macro DEBOUNCE_SYNC_EN defined: din passes a 2-flop synchronizer before the FSM; total latency STABLE_CYCLES+2 edges.
REQ-025 DEBOUNCE_SYNC_EN undefined: s=din, no synchronizer flops instantiated, latency STABLE_CYCLES edges; din must then be synchronous to clk.

Structure
REQ-026 Package debounce_pkg: state enum type (4 states), SYNC_STAGES=2, GLITCH_W=8, GLITCH_MAX=255.
REQ-027 One sub-module sync_2ff (clk, resetn, d, q), instantiated only under DEBOUNCE_SYNC_EN.

Verification (STABLE_CYCLES=4; edge counts from first edge sampling din; no sync unless stated)
REQ-028 Reset held 3 cycles with din=1 -> dout=0, busy=0, glitch_cnt=0 throughout reset.
REQ-029 din 0->1 held 10 cycles -> busy=1 after edge 1, dout=1 after edge 4, busy=0 after edge 4.
REQ-030 din high for 3 edges then low -> dout stays 0, glitch_cnt=1; repeated 300 times -> glitch_cnt=255.
REQ-031 From dout=1, din low 2 edges, high 1, low 4 -> glitch_cnt+1, dout=0 only after the 4th consecutive low edge.
REQ-032 clr_glitch=1 on the same edge as a rejected candidate -> glitch_cnt=0.
REQ-033 DEBOUNCE_SYNC_EN defined, din 0->1 held -> dout=1 after edge 6; resetn=0 at edge 3 -> dout=0, glitch_cnt unchanged.
